// File: rtl/ttc_count_event_lite30.sv
// ttc_count_event_lite30
// Lite triple-timer-counter event generator: one 16-bit up/down counter with
// overflow and interval modes, three match comparators and single-cycle
// interval / match / overflow / restart pulses for the interrupt stage.
// Optional feature macro: TTC_PRESCALER_EN (2^P prescaler taken from ctrl[8:5]).
// With the macro undefined every enabled cycle is a tick and ctrl[8:5] reads 0.
module ttc_count_event_lite30 (
    input  logic        pclk30,
    input  logic        n_p_reset30,
    input  logic [15:0] pwdata30,
    input  logic        cntr_ctrl_reg_sel30,
    input  logic        interval_reg_sel30,
    input  logic        match_1_reg_sel30,
    input  logic        match_2_reg_sel30,
    input  logic        match_3_reg_sel30,
    output logic [15:0] counter_val_out30,
    output logic [8:0]  cntr_ctrl_out30,
    output logic        interval_intr30,
    output logic [3:1]  match_intr30,
    output logic        overflow_intr30,
    output logic        restart30
);

    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam logic [15:0] CNT_ZERO = 16'h0000;

    // Stored control fields
    logic        ctrl_dis;
    logic        ctrl_int;
    logic        ctrl_dec;
    logic        ctrl_men;
    logic [3:0]  ctrl_pre;

    // Interval and match registers
    logic [15:0] interval_reg;
    logic [15:0] match_1_reg;
    logic [15:0] match_2_reg;
    logic [15:0] match_3_reg;

    // Counter state and next-state terms
    logic [15:0] count;
    logic [15:0] cnt_nxt;
    logic        int_nxt;
    logic        ovf_nxt;
    logic [3:1]  match_nxt;
    logic [17:0] step_res;
    logic [15:0] restart_val;
    logic        restart_req;
    logic        pre_tick;
    logic        tick;

    // One up-count step: returns {interval_event, overflow_event, next_count}.
    // The interval compare is equality only, so an interval shrunk below the
    // current count lets the counter run on to FFFF and wrap as an overflow.
    function automatic logic [17:0] count_up_step(input logic [15:0] cur,
                                                  input logic        imode,
                                                  input logic [15:0] ivl);
        logic [17:0] res;
        if (imode && (cur == ivl)) begin
            res = {1'b1, 1'b0, CNT_ZERO};
        end else if (cur == CNT_MAX) begin
            res = {1'b0, 1'b1, CNT_ZERO};
        end else begin
            res = {1'b0, 1'b0, cur + 16'd1};
        end
        return res;
    endfunction

    // One down-count step: returns {interval_event, underflow_event, next_count}.
    function automatic logic [17:0] count_down_step(input logic [15:0] cur,
                                                    input logic        imode,
                                                    input logic [15:0] ivl);
        logic [17:0] res;
        if (cur == CNT_ZERO) begin
            if (imode) begin
                res = {1'b1, 1'b0, ivl};
            end else begin
                res = {1'b0, 1'b1, CNT_MAX};
            end
        end else begin
            res = {1'b0, 1'b0, cur - 16'd1};
        end
        return res;
    endfunction

    // A restart is a control write with bit 4 set; the bit itself is never stored
    assign restart_req = cntr_ctrl_reg_sel30 && pwdata30[4];

    // Restart load value follows the direction/mode being written alongside it
    assign restart_val = !pwdata30[2] ? CNT_ZERO :
                         (pwdata30[1] ? interval_reg : CNT_MAX);

    assign tick = !ctrl_dis && pre_tick;

`ifdef TTC_PRESCALER_EN
    logic [15:0] pre_cnt;
    logic [15:0] pre_mask;
    logic        pre_clr;

    // Terminal value of the prescaler is 2^P - 1; P = 0 gives a tick every cycle
    assign pre_mask = ~(16'hFFFF << ctrl_pre);
    assign pre_tick = (pre_cnt == pre_mask);
    assign pre_clr  = restart_req ||
                      (cntr_ctrl_reg_sel30 && (pwdata30[8:5] != ctrl_pre));

    // Prescale counter: advances on enabled cycles, holds its phase while disabled
    always_ff @(posedge pclk30 or negedge n_p_reset30) begin
        if (!n_p_reset30) begin
            pre_cnt <= 16'h0000;
        end else if (pre_clr) begin
            pre_cnt <= 16'h0000;
        end else if (!ctrl_dis) begin
            pre_cnt <= pre_tick ? 16'h0000 : pre_cnt + 16'd1;
        end
    end

    // Prescale field of the control register
    always_ff @(posedge pclk30 or negedge n_p_reset30) begin
        if (!n_p_reset30) begin
            ctrl_pre <= 4'd0;
        end else if (cntr_ctrl_reg_sel30) begin
            ctrl_pre <= pwdata30[8:5];
        end
    end
`else
    assign pre_tick = 1'b1;
    assign ctrl_pre = 4'd0;
`endif

    // Control register low bits; reset leaves the counter disabled
    always_ff @(posedge pclk30 or negedge n_p_reset30) begin
        if (!n_p_reset30) begin
            ctrl_dis <= 1'b1;
            ctrl_int <= 1'b0;
            ctrl_dec <= 1'b0;
            ctrl_men <= 1'b0;
        end else if (cntr_ctrl_reg_sel30) begin
            ctrl_dis <= pwdata30[0];
            ctrl_int <= pwdata30[1];
            ctrl_dec <= pwdata30[2];
            ctrl_men <= pwdata30[3];
        end
    end

    // Interval and match registers, each loaded by its own select strobe
    always_ff @(posedge pclk30 or negedge n_p_reset30) begin
        if (!n_p_reset30) begin
            interval_reg <= CNT_MAX;
            match_1_reg  <= CNT_ZERO;
            match_2_reg  <= CNT_ZERO;
            match_3_reg  <= CNT_ZERO;
        end else begin
            if (interval_reg_sel30) interval_reg <= pwdata30;
            if (match_1_reg_sel30)  match_1_reg  <= pwdata30;
            if (match_2_reg_sel30)  match_2_reg  <= pwdata30;
            if (match_3_reg_sel30)  match_3_reg  <= pwdata30;
        end
    end

    // Next count and event flags for a tick; matches compare against the new count
    always_comb begin
        cnt_nxt   = count;
        int_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        match_nxt = 3'b000;
        step_res  = {2'b00, count};
        if (tick) begin
            step_res = ctrl_dec ? count_down_step(count, ctrl_int, interval_reg)
                                : count_up_step(count, ctrl_int, interval_reg);
            cnt_nxt  = step_res[15:0];
            int_nxt  = step_res[17];
            ovf_nxt  = step_res[16];
            if (ctrl_men) begin
                match_nxt = {match_3_reg == cnt_nxt,
                             match_2_reg == cnt_nxt,
                             match_1_reg == cnt_nxt};
            end
        end
    end

    // Counter and event pulses; a restart overrides any coincident tick and its events
    always_ff @(posedge pclk30 or negedge n_p_reset30) begin
        if (!n_p_reset30) begin
            count           <= CNT_ZERO;
            interval_intr30 <= 1'b0;
            match_intr30    <= 3'b000;
            overflow_intr30 <= 1'b0;
            restart30       <= 1'b0;
        end else if (restart_req) begin
            count           <= restart_val;
            interval_intr30 <= 1'b0;
            match_intr30    <= 3'b000;
            overflow_intr30 <= 1'b0;
            restart30       <= 1'b1;
        end else begin
            count           <= cnt_nxt;
            interval_intr30 <= int_nxt;
            match_intr30    <= match_nxt;
            overflow_intr30 <= ovf_nxt;
            restart30       <= 1'b0;
        end
    end

    assign counter_val_out30 = count;
    assign cntr_ctrl_out30   = {ctrl_pre, 1'b0, ctrl_men, ctrl_dec, ctrl_int, ctrl_dis};

endmodule

// File: tb/tb_ttc_count_event_lite30.sv
// Bench for ttc_count_event_lite30: a reference model computes the expected
// outputs as each cycle of stimulus is driven and queues them; a monitor pops
// and compares one entry per clock after the DUT edge.
`timescale 1ns/1ps
module tb_ttc_count_event_lite30;

    logic        pclk30 = 1'b0;
    logic        n_p_reset30;
    logic [15:0] pwdata30;
    logic        cntr_ctrl_reg_sel30;
    logic        interval_reg_sel30;
    logic        match_1_reg_sel30;
    logic        match_2_reg_sel30;
    logic        match_3_reg_sel30;
    logic [15:0] counter_val_out30;
    logic [8:0]  cntr_ctrl_out30;
    logic        interval_intr30;
    logic [3:1]  match_intr30;
    logic        overflow_intr30;
    logic        restart30;

    ttc_count_event_lite30 dut (
        .pclk30              (pclk30),
        .n_p_reset30         (n_p_reset30),
        .pwdata30            (pwdata30),
        .cntr_ctrl_reg_sel30 (cntr_ctrl_reg_sel30),
        .interval_reg_sel30  (interval_reg_sel30),
        .match_1_reg_sel30   (match_1_reg_sel30),
        .match_2_reg_sel30   (match_2_reg_sel30),
        .match_3_reg_sel30   (match_3_reg_sel30),
        .counter_val_out30   (counter_val_out30),
        .cntr_ctrl_out30     (cntr_ctrl_out30),
        .interval_intr30     (interval_intr30),
        .match_intr30        (match_intr30),
        .overflow_intr30     (overflow_intr30),
        .restart30           (restart30)
    );

    always #5 pclk30 = ~pclk30;

    typedef struct packed {
        logic [15:0] cnt;
        logic [8:0]  ctrl;
        logic [5:0]  pls;   // {interval, match[3:1], overflow, restart}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [15:0] m_cnt, m_ivl, m_m1, m_m2, m_m3;
    logic        m_dis, m_int, m_dec, m_men;
    logic [3:0]  m_p;
    int          m_pres;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 16'h0000;
        m_ivl  = 16'hFFFF;
        m_m1   = 16'h0000;
        m_m2   = 16'h0000;
        m_m3   = 16'h0000;
        m_dis  = 1'b1;
        m_int  = 1'b0;
        m_dec  = 1'b0;
        m_men  = 1'b0;
        m_p    = 4'd0;
        m_pres = 0;
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the DUT must show after the next rising edge
    task automatic step(input logic sc, input logic si, input logic [3:1] sm, input logic [15:0] d);
        logic        tk, rs, ie, oe, re;
        logic [15:0] nc;
        logic [3:1]  me;
        int          lim;
        exp_t        e;
        @(negedge pclk30);
        cntr_ctrl_reg_sel30 = sc;
        interval_reg_sel30  = si;
        match_1_reg_sel30   = sm[1];
        match_2_reg_sel30   = sm[2];
        match_3_reg_sel30   = sm[3];
        pwdata30            = d;
`ifdef TTC_PRESCALER_EN
        lim = 1 << m_p;
`else
        lim = 1;
`endif
        tk = !m_dis && ((m_pres + 1) == lim);
        rs = sc && d[4];
        nc = m_cnt; ie = 1'b0; oe = 1'b0; re = 1'b0; me = 3'b000;
        if (rs) begin
            re = 1'b1;
            if (!d[2])     nc = 16'h0000;
            else if (d[1]) nc = m_ivl;
            else           nc = 16'hFFFF;
        end else if (tk) begin
            if (!m_dec) begin
                if (m_int && m_cnt == m_ivl) begin nc = 16'h0000; ie = 1'b1; end
                else if (m_cnt == 16'hFFFF)  begin nc = 16'h0000; oe = 1'b1; end
                else nc = m_cnt + 16'd1;
            end else begin
                if (m_cnt == 16'h0000) begin
                    if (m_int) begin nc = m_ivl;    ie = 1'b1; end
                    else       begin nc = 16'hFFFF; oe = 1'b1; end
                end else begin
                    nc = m_cnt - 16'd1;
                end
            end
            if (m_men) me = {m_m3 == nc, m_m2 == nc, m_m1 == nc};
        end
        // prescaler phase
        if (rs) m_pres = 0;
`ifdef TTC_PRESCALER_EN
        else if (sc && d[8:5] != m_p) m_pres = 0;
`endif
        else if (!m_dis) m_pres = tk ? 0 : m_pres + 1;
        // register writes
        if (sc) begin
            m_dis = d[0]; m_int = d[1]; m_dec = d[2]; m_men = d[3];
`ifdef TTC_PRESCALER_EN
            m_p = d[8:5];
`endif
        end
        if (si)    m_ivl = d;
        if (sm[1]) m_m1 = d;
        if (sm[2]) m_m2 = d;
        if (sm[3]) m_m3 = d;
        m_cnt = nc;
        e.cnt  = nc;
        e.ctrl = {m_p, 1'b0, m_men, m_dec, m_int, m_dis};
        e.pls  = {ie, me, oe, re};
        sb.push_back(e);
    endtask

    task automatic wr_ctrl(input logic [15:0] d);
        step(1'b1, 1'b0, 3'b000, d);
    endtask

    task automatic wr_ivl(input logic [15:0] d);
        step(1'b0, 1'b1, 3'b000, d);
    endtask

    task automatic wr_match(input int n, input logic [15:0] d);
        logic [3:1] sm;
        sm = 3'b000;
        sm[n] = 1'b1;
        step(1'b0, 1'b0, sm, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 3'b000, 16'($urandom));
    endtask

    task automatic drain();
        @(posedge pclk30);
        #3;
    endtask

    // Monitor: compare one queued expectation per clock, just after the rising edge
    always begin
        @(posedge pclk30);
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_val("count", 32'(counter_val_out30), 32'(mon_e.cnt));
            check_val("ctrl", 32'(cntr_ctrl_out30), 32'(mon_e.ctrl));
            check_val("pulses", 32'({interval_intr30, match_intr30, overflow_intr30, restart30}),
                      32'(mon_e.pls));
        end
    end

    initial begin
        logic [15:0] d;
        logic [3:1]  sm;
        int          r;
        n_p_reset30         = 1'b0;
        pwdata30            = 16'h0000;
        cntr_ctrl_reg_sel30 = 1'b0;
        interval_reg_sel30  = 1'b0;
        match_1_reg_sel30   = 1'b0;
        match_2_reg_sel30   = 1'b0;
        match_3_reg_sel30   = 1'b0;
        model_reset();
        repeat (2) @(posedge pclk30);
        #1;
        check_val("rst_count", 32'(counter_val_out30), 32'h0);
        check_val("rst_ctrl", 32'(cntr_ctrl_out30), 32'h001);
        check_val("rst_pulses", 32'({interval_intr30, match_intr30, overflow_intr30, restart30}), 32'h0);
        @(negedge pclk30);
        n_p_reset30 = 1'b1;

        // Overflow mode, counting up from reset, then wrap through FFFF both ways
        wr_ctrl(16'h0000);
        idle(6);
        wr_ctrl(16'h0014);          // restart down/overflow -> FFFF
        wr_ctrl(16'h0000);          // switch to up, continue from current count
        idle(4);
        wr_ctrl(16'h0014);
        idle(1);
        wr_ctrl(16'h0010);          // restart up -> 0
        wr_ctrl(16'h0004);          // down from 0 -> underflow
        idle(2);

        // Interval up with interval 5
        wr_ivl(16'd5);
        wr_ctrl(16'h0012);
        idle(14);

        // Interval down with coincident match pulses
        wr_ivl(16'd10);
        wr_match(1, 16'd7);
        wr_match(3, 16'd7);
        wr_match(2, 16'd3);
        wr_ctrl(16'h001E);
        idle(25);

        // Interval shrunk below the count: runs to FFFF and wraps as overflow
        wr_ctrl(16'h0014);
        wr_ivl(16'd5);
        wr_ctrl(16'h0002);
        idle(9);

        // Interval 0: stays at 0 with an interval pulse per tick, both directions
        wr_ivl(16'd0);
        wr_ctrl(16'h0012);
        idle(3);
        wr_ctrl(16'h0016);
        idle(3);

        // Restart precedence while running at 0x1234, then while disabled
        wr_ivl(16'h1234);
        wr_ctrl(16'h0016);
        wr_ctrl(16'h0000);
        idle(2);
        wr_ctrl(16'h0010);
        idle(2);
        wr_ctrl(16'h0011);
        idle(3);
        wr_match(1, 16'h0000);
        wr_ctrl(16'h0018);          // restart to 0 with match_1 = 0: no match pulse
        idle(2);

        // Prescaler P = 2, disable mid-period, re-enable, then change P
        wr_ctrl(16'h0050);
        idle(6);
        wr_ctrl(16'h0041);
        idle(3);
        wr_ctrl(16'h0040);
        idle(9);
        wr_ctrl(16'h0020);
        idle(6);
        wr_ctrl(16'h0000);
        idle(2);

        // Random register traffic
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 11));
            d  = 16'($urandom);
            sm = 3'b000;
            if (r == 0) begin
                d[0]   = ($urandom_range(0, 5) == 0);
                d[4]   = ($urandom_range(0, 3) == 0);
                d[8:5] = 4'($urandom_range(0, 3));
                step(1'b1, 1'b0, 3'b000, d);
            end else if (r == 1) begin
                step(1'b0, 1'b1, 3'b000, 16'($urandom_range(0, 40)));
            end else if (r == 2) begin
                sm[$urandom_range(1, 3)] = 1'b1;
                step(1'b0, 1'b0, sm, 16'($urandom_range(0, 40)));
            end else begin
                step(1'b0, 1'b0, 3'b000, d);
            end
        end

        // Asynchronous reset mid-run at count 0x0042 with a match pulse high
        wr_match(1, 16'h0042);
        wr_ctrl(16'h0018);
        idle(16'h42);
        drain();
        check_val("pre_rst_count", 32'(counter_val_out30), 32'h0042);
        check_val("pre_rst_match", 32'(match_intr30), 32'h1);
        n_p_reset30 = 1'b0;
        #1;
        check_val("async_count", 32'(counter_val_out30), 32'h0);
        check_val("async_ctrl", 32'(cntr_ctrl_out30), 32'h001);
        check_val("async_pulses", 32'({interval_intr30, match_intr30, overflow_intr30, restart30}), 32'h0);
        sb.delete();
        model_reset();
        @(negedge pclk30);
        n_p_reset30 = 1'b1;
        wr_ctrl(16'h0000);
        idle(3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
